// File: rtl/huff_pkg.sv
// Shared constants, scheduler state type and mask popcount for the Huffman job scheduler.
package huff_pkg;

    localparam int unsigned NSYM   = 3;
    localparam int unsigned SYM_W  = 8;
    localparam int unsigned FREQ_W = 3;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned LEN_W  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StKick,
        StWait,
        StResp
    } sched_state_t;

    function automatic logic [LEN_W-1:0] popcount_code(input logic [CODE_W-1:0] mask);
        logic [LEN_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(CODE_W); i++) begin
            cnt = cnt + {{(LEN_W-1){1'b0}}, mask[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the slot after the last accepted grant.
module rr_arbiter #(
    parameter int unsigned NReq = 2,
    localparam int unsigned IdxW = (NReq > 1) ? $clog2(NReq) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NReq-1:0] req_i,
    input  logic            accept_i,
    output logic [NReq-1:0] gnt_o,
    output logic [IdxW-1:0] gnt_idx_o
);

    logic [IdxW-1:0] last_q, last_d;
    logic            found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = last_q;
        found     = 1'b0;
        for (int k = 1; k <= int'(NReq); k++) begin
            for (int i = 0; i < int'(NReq); i++) begin
                if (!found && req_i[i] && (i == (int'(last_q) + k) % int'(NReq))) begin
                    found     = 1'b1;
                    gnt_o[i]  = 1'b1;
                    gnt_idx_o = IdxW'(i);
                end
            end
        end
    end

    assign last_d = accept_i ? gnt_idx_o : last_q;

    // Pointer parks on the last slot so requester 0 wins first after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= IdxW'(NReq - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/huff_job_sched.sv
// Shares one Huffman encoder between NREQ requesters: grant, kick via reset, wait for done,
// return per-symbol code and lengths on a valid/ready result channel.
module huff_job_sched
    import huff_pkg::*;
#(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned TIMEOUT_CYC = 32,
    localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid_i,
    output logic [NREQ-1:0]            req_ready_o,
    input  logic [NREQ*NSYM*SYM_W-1:0] req_data_i,
    input  logic [NREQ*NSYM*FREQ_W-1:0] req_freq_i,
    output logic                       enc_reset_o,
    output logic [NSYM*SYM_W-1:0]      enc_data_o,
    output logic [NSYM*FREQ_W-1:0]     enc_freq_o,
    input  logic [NSYM*CODE_W-1:0]     enc_value_i,
    input  logic [NSYM*CODE_W-1:0]     enc_mask_i,
    input  logic                       enc_done_i,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [IdW-1:0]             res_id_o,
    output logic [NSYM*CODE_W-1:0]     res_code_o,
    output logic [NSYM*LEN_W-1:0]      res_len_o,
    output logic                       res_err_o,
    output logic                       busy_o
);

    localparam int unsigned DataW  = NSYM * SYM_W;
    localparam int unsigned FreqW  = NSYM * FREQ_W;
    localparam int unsigned CodeVW = NSYM * CODE_W;
    localparam int unsigned LenVW  = NSYM * LEN_W;
    localparam int unsigned CntW   = $clog2(TIMEOUT_CYC);

    sched_state_t      state_q, state_d;
    logic [DataW-1:0]  job_data_q, job_data_d;
    logic [FreqW-1:0]  job_freq_q, job_freq_d;
    logic [IdW-1:0]    job_id_q, job_id_d;
    logic              seen_low_q, seen_low_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              res_valid_q, res_valid_d;
    logic [IdW-1:0]    res_id_q, res_id_d;
    logic [CodeVW-1:0] res_code_q, res_code_d;
    logic [LenVW-1:0]  res_len_q, res_len_d;
    logic              res_err_q, res_err_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [IdW-1:0]    arb_idx;
    logic              accept;
    logic [DataW-1:0]  sel_data;
    logic [FreqW-1:0]  sel_freq;
    logic [LenVW-1:0]  mask_len;

    rr_arbiter #(
        .NReq(NREQ)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req_valid_i),
        .accept_i (accept),
        .gnt_o    (arb_gnt),
        .gnt_idx_o(arb_idx)
    );

    // Grants are suppressed while reset is high so nothing is accepted and then dropped.
    assign req_ready_o = (state_q == StIdle && !reset) ? arb_gnt : '0;
    assign accept      = |req_ready_o;

    always_comb begin
        sel_data = '0;
        sel_freq = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (arb_gnt[i]) begin
                sel_data = sel_data | req_data_i[i*DataW +: DataW];
                sel_freq = sel_freq | req_freq_i[i*FreqW +: FreqW];
            end
        end
    end

    always_comb begin
        mask_len = '0;
        for (int k = 0; k < int'(NSYM); k++) begin
            mask_len[k*LEN_W +: LEN_W] = popcount_code(enc_mask_i[k*CODE_W +: CODE_W]);
        end
    end

    always_comb begin
        state_d     = state_q;
        job_data_d  = job_data_q;
        job_freq_d  = job_freq_q;
        job_id_d    = job_id_q;
        seen_low_d  = seen_low_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_code_d  = res_code_q;
        res_len_d   = res_len_q;
        res_err_d   = res_err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    job_data_d = sel_data;
                    job_freq_d = sel_freq;
                    job_id_d   = arb_idx;
                    state_d    = StKick;
                end
            end
            StKick: begin
                seen_low_d = 1'b0;
                cnt_d      = '0;
                state_d    = StWait;
            end
            StWait: begin
                seen_low_d = seen_low_q | ~enc_done_i;
                cnt_d      = cnt_q + CntW'(1);
                // A done held over from the previous job only counts after a low has been seen.
                if (seen_low_q && enc_done_i) begin
                    res_valid_d = 1'b1;
                    res_id_d    = job_id_q;
                    res_code_d  = enc_value_i;
                    res_len_d   = mask_len;
                    res_err_d   = 1'b0;
                    state_d     = StResp;
                end else if (cnt_q == CntW'(TIMEOUT_CYC - 2)) begin
                    res_valid_d = 1'b1;
                    res_id_d    = job_id_q;
                    res_code_d  = '0;
                    res_len_d   = '0;
                    res_err_d   = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            job_data_q  <= '0;
            job_freq_q  <= '0;
            job_id_q    <= '0;
            seen_low_q  <= 1'b0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_code_q  <= '0;
            res_len_q   <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            job_data_q  <= job_data_d;
            job_freq_q  <= job_freq_d;
            job_id_q    <= job_id_d;
            seen_low_q  <= seen_low_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_code_q  <= res_code_d;
            res_len_q   <= res_len_d;
            res_err_q   <= res_err_d;
        end
    end

    assign enc_reset_o = reset | (state_q == StKick);
    assign enc_data_o  = job_data_q;
    assign enc_freq_o  = job_freq_q;
    assign res_valid_o = res_valid_q;
    assign res_id_o    = res_id_q;
    assign res_code_o  = res_code_q;
    assign res_len_o   = res_len_q;
    assign res_err_o   = res_err_q;
    assign busy_o      = (state_q != StIdle);

endmodule
